// File: rtl/mdu_unit_pkg.sv
// Shared MDU operation codes, controller state type and the arithmetic helper
// that produces the 64-bit HI/LO result for an accepted operation.
package mdu_unit_pkg;

  localparam logic [3:0] MDU_NONE = 4'd0;
  localparam logic [3:0] MULT     = 4'd1;
  localparam logic [3:0] MULTU    = 4'd2;
  localparam logic [3:0] DIV      = 4'd3;
  localparam logic [3:0] DIVU     = 4'd4;
  localparam logic [3:0] MFHI     = 4'd5;
  localparam logic [3:0] MFLO     = 4'd6;
  localparam logic [3:0] MTHI     = 4'd7;
  localparam logic [3:0] MTLO     = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // wr is cleared for a divide by zero so the writeback leaves HI/LO alone.
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // True for the four operations that occupy the unit for several cycles.
  function automatic logic is_arith(input logic [3:0] op);
    logic r;
    case (op)
      MULT, MULTU, DIV, DIVU: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the operations that use the divide latency.
  function automatic logic is_div(input logic [3:0] op);
    logic r;
    case (op)
      DIV, DIVU: r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Full result of an arithmetic op. Signed divide works on magnitudes so the
  // 0x80000000 / -1 corner falls out naturally (quotient wraps to 0x80000000).
  function automatic mdu_res_t mdu_compute(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    mdu_res_t           res;
    logic signed [63:0] s_prod;
    logic [63:0]        u_prod;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        dvsr;
    logic [31:0]        q;
    logic [31:0]        r;
    s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    u_prod = {32'd0, a} * {32'd0, b};
    a_neg  = (op == DIV) ? a[31] : 1'b0;
    b_neg  = (op == DIV) ? b[31] : 1'b0;
    mag_a  = a_neg ? (32'd0 - a) : a;
    mag_b  = b_neg ? (32'd0 - b) : b;
    // Substitute a divisor of 1 for zero; the result is discarded anyway.
    dvsr   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q      = mag_a / dvsr;
    r      = mag_a % dvsr;
    case (op)
      MULT: begin
        res.wr = 1'b1;
        res.hi = s_prod[63:32];
        res.lo = s_prod[31:0];
      end
      MULTU: begin
        res.wr = 1'b1;
        res.hi = u_prod[63:32];
        res.lo = u_prod[31:0];
      end
      DIV, DIVU: begin
        res.wr = (b != 32'd0);
        res.lo = (a_neg ^ b_neg) ? (32'd0 - q) : q;
        res.hi = a_neg ? (32'd0 - r) : r;
      end
      default: begin
        res.wr = 1'b0;
        res.hi = 32'd0;
        res.lo = 32'd0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed latency,
// services mthi/mtlo and the combinational mfhi/mflo read path.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e     r_state;
  mdu_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;
  mdu_res_t       r_pend;
  mdu_res_t       w_res;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic           w_accept;
  logic           w_done;
  logic           w_idle_move;

  assign w_res  = mdu_compute(MDUop, A, B);
  assign w_load = is_div(MDUop) ? DIV_LOAD : MULT_LOAD;
  // mthi/mtlo only land when nothing is in flight and no start is presented.
  assign w_idle_move = (r_state == ST_IDLE) && !start;

  assign busy = (r_state == ST_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Next-state logic: accept in IDLE, finish when the counter is about to hit 0.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && is_arith(MDUop)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt <= CNT_ONE) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cycle counter and pending result; a start while busy never reaches here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else if (w_accept) begin
      r_cnt  <= w_load;
      r_pend <= w_res;
    end else if (r_state == ST_RUN) begin
      r_cnt  <= r_cnt - CNT_ONE;
      r_pend <= r_pend;
    end else begin
      r_cnt  <= r_cnt;
      r_pend <= r_pend;
    end
  end

  // HI/LO update: writeback at completion, or a move-to while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done && r_pend.wr) begin
      r_hi <= r_pend.hi;
      r_lo <= r_pend.lo;
    end else if (w_idle_move && (MDUop == MTHI)) begin
      r_hi <= A;
      r_lo <= r_lo;
    end else if (w_idle_move && (MDUop == MTLO)) begin
      r_hi <= r_hi;
      r_lo <= A;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // Read mux for mfhi/mflo; everything else reads as zero.
  always_comb begin
    MDU_out = 32'd0;
    case (MDUop)
      MFHI:    MDU_out = r_hi;
      MFLO:    MDU_out = r_lo;
      default: MDU_out = 32'd0;
    endcase
  end

endmodule
